pc_unit: RTL
============

Name: pc_unit

Overview:
- Program-counter stage of the single-cycle MIPS CPU; sits downstream of the immediate extender and consumes its 32-bit extended immediate for branch targets.
- Holds the PC register, computes PC+4, and selects the next PC from sequential, branch, jump or register (jr) sources.
- Adds a boot cycle, a sticky halt and a misaligned-target trap, plus a retired-instruction counter for the test bench and debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PCWre  in  1  PC write enable from the control unit.
- PCSrc  in  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump, 11 = jr.
- ImExtend  in  32  extended immediate from the extender (branch offset in words).
- JumpAddr  in  26  instr[25:0] for j/jal.
- RegRs  in  32  rs register value for jr.
- Halt  in  1  halt instruction decoded.
- PC  out  32  current PC; drives instruction memory.
- PC4  out  32  PC+4, used as the jal link value.
- PCValid  out  1  high only in RUN.
- Halted  out  1  high in HALTED.
- AddrErr  out  1  sticky misaligned-target flag.
- Retired  out  CNT_W  count of PC advances.

Behaviour:
- Reset is asynchronous and active-high; the clock is CLK.
- Reset values: PC=RESET_PC, state=BOOT, PCValid=0, Halted=0, AddrErr=0, Retired=0. PC4 follows PC combinationally, so it is RESET_PC+4 during reset.
- States:
  - BOOT: exactly one cycle after Reset deasserts, giving instruction memory a settle cycle. PC is held and all inputs are ignored. Next state is RUN.
  - RUN: normal operation.
  - HALTED: PC is frozen and all inputs are ignored. Only Reset exits this state.
- Next-PC computation (combinational, all arithmetic mod 2^32):
  - 00: PC+4.
  - 01: PC+4 + (ImExtend<<2).
  - 10: {PC4[31:28], JumpAddr, 2'b00}.
  - 11: RegRs.
- RUN edge priority, highest first:
  1. Halt=1: go to HALTED; PC and Retired unchanged; the halt instruction's address remains on PC.
  2. PCWre=1 and next-PC[1:0]!=2'b00 (only reachable via jr): AddrErr<=1, go to HALTED, PC unchanged.
  3. PCWre=1: PC<=next-PC; Retired<=Retired+1, wrapping at 2^CNT_W.
  4. PCWre=0: hold PC and Retired.
- Latency: the new PC is visible one edge after selection. Next-PC and PC4 have zero-cycle combinational latency.
- Wrap-around: PC=32'hFFFF_FFFC with PCSrc=00 gives 32'h0000_0000 and does not trap.
- Branch targets wrap mod 2^32 in either direction.
- Reset asserted mid-operation, in any state, immediately forces the reset values without waiting for a clock edge.
- AddrErr and Halted clear only on Reset.
- Inputs with X values are ignored outside RUN.

Decomposition:
- Shared package (cpu_pkg): PCSrc encodings PCSRC_SEQ/BR/J/JR, state encodings ST_BOOT/ST_RUN/ST_HALT, and the RESET_PC default.
- One sub-module: next_pc_mux (purely combinational). It takes PC, ImExtend, JumpAddr, RegRs and PCSrc, and outputs next-PC and PC4. pc_unit instantiates it and owns the state machine, PC register and counter.

Test Plan:
- Reset then release; PCSrc=00, PCWre=1 -> PC=0 for the BOOT cycle with PCValid=0, then 0x4, 0x8, 0xC; Retired=3 after 4 edges past reset.
- PC=0x100, PCSrc=01, ImExtend=32'hFFFF_FFFC (-4) -> PC=0x0F4. Then ImExtend=0x10 from 0x0F4 -> PC=0x138.
- PC=0x8000_0010, PCSrc=10, JumpAddr=26'h000_0040 -> PC=0x8000_0100. Then PCSrc=11, RegRs=0x2000 -> PC=0x2000.
- PCSrc=11, RegRs=0x2002 -> PC holds, AddrErr=1, Halted=1; further inputs leave PC unchanged.
- Halt=1 at PC=0x40 together with PCWre=1 -> PC stays 0x40, Halted=1, Retired unchanged; assert Reset asynchronously mid-cycle -> PC=0 and flags clear before the next edge.
- Preload PC=0xFFFF_FFFC, PCSrc=00 -> PC=0x0, no AddrErr. With PCWre=0 for 3 edges -> PC and Retired hold.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: PC-source and PC-stage state encodings,
// the default reset vector and a small alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcSrcE;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } stateE;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic isAligned(
    input logic [31:0] addr
  );
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC mux: computes PC+4 and picks seq/branch/jump/jr target.
// Ports: pc, imExtend, jumpAddr, regRs, pcSrc in; nextPc, pc4 out.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imExtend,
  input  logic [25:0] jumpAddr,
  input  logic [31:0] regRs,
  input  logic [1:0]  pcSrc,
  output logic [31:0] nextPc,
  output logic [31:0] pc4
);

  logic [31:0] brOff;
  logic [31:0] brTgt;
  logic [31:0] jTgt;

  assign pc4   = pc + 32'd4;
  // Word offset to byte offset; upper bits drop off mod 2^32.
  assign brOff = {imExtend[29:0], 2'b00};
  assign brTgt = pc4 + brOff;
  assign jTgt  = {pc4[31:28], jumpAddr, 2'b00};

  always_comb begin
    nextPc = pc4;
    unique case (pcSrcE'(pcSrc))
      PCSRC_SEQ: nextPc = pc4;
      PCSRC_BR:  nextPc = brTgt;
      PCSRC_J:   nextPc = jTgt;
      PCSRC_JR:  nextPc = regRs;
      default:   nextPc = pc4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// PC stage: PC register, boot/run/halt control, misaligned trap, retire count.
// Ports: CLK, Reset, PCWre, PCSrc, ImExtend, JumpAddr, RegRs, Halt in;
//        PC, PC4, PCValid, Halted, AddrErr, Retired out.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [31:0]      ImExtend,
  input  logic [25:0]      JumpAddr,
  input  logic [31:0]      RegRs,
  input  logic             Halt,
  output logic [31:0]      PC,
  output logic [31:0]      PC4,
  output logic             PCValid,
  output logic             Halted,
  output logic             AddrErr,
  output logic [CNT_W-1:0] Retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stateE            stateQ;
  stateE            stateD;
  logic [31:0]      pcQ;
  logic [31:0]      pcD;
  logic [CNT_W-1:0] retiredQ;
  logic [CNT_W-1:0] retiredD;
  logic             addrErrQ;
  logic             addrErrD;
  logic [31:0]      nextPc;

  next_pc_mux uMux (
    .pc       (pcQ),
    .imExtend (ImExtend),
    .jumpAddr (JumpAddr),
    .regRs    (RegRs),
    .pcSrc    (PCSrc),
    .nextPc   (nextPc),
    .pc4      (PC4)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stateQ   <= ST_BOOT;
      pcQ      <= RESET_PC;
      retiredQ <= '0;
      addrErrQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      pcQ      <= pcD;
      retiredQ <= retiredD;
      addrErrQ <= addrErrD;
    end
  end

  // Inputs are only looked at in RUN, so BOOT and HALT are
  // immune to whatever (possibly X) the datapath presents.
  always_comb begin
    stateD   = stateQ;
    pcD      = pcQ;
    retiredD = retiredQ;
    addrErrD = addrErrQ;
    unique case (stateQ)
      ST_BOOT: stateD = ST_RUN;
      ST_RUN: begin
        // Halt and PCWre may both be high; halt wins.
        priority case (1'b1)
          Halt: stateD = ST_HALT;
          PCWre && !isAligned(nextPc): begin
            addrErrD = 1'b1;
            stateD   = ST_HALT;
          end
          PCWre: begin
            pcD      = nextPc;
            retiredD = retiredQ + CNT_ONE;
          end
          default: ;
        endcase
      end
      ST_HALT: stateD = ST_HALT;
      default: stateD = ST_HALT;
    endcase
  end

  assign PC      = pcQ;
  assign PCValid = stateQ == ST_RUN;
  assign Halted  = stateQ == ST_HALT;
  assign AddrErr = addrErrQ;
  assign Retired = retiredQ;

endmodule
